// File: rtl/dcache_line_memory.sv
// Line-granular (256-bit) responder for the dcache memory port: fixed-latency ack, one request at a time.
// Optional DCACHE_MEM_ADDR_CHECK_EN adds err_o and rejects misaligned or out-of-range addresses.
module dcache_line_memory #(
  parameter int LATENCY    = 10,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
`ifdef DCACHE_MEM_ADDR_CHECK_EN
  output logic         err_o,
`endif
  output logic         ack_o,
  output logic [255:0] data_o
);

  localparam int         LINES    = 1 << DEPTH_LOG2;
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_e;

  // Handshake: enable_i is a level held by the initiator until ack_o; ack_o is a
  // one-cycle pulse, and enable_i low while waiting abandons the request.
  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic                    wr_q, wr_d;
  logic                    err_q, err_d;
  logic [255:0]            wdata_q, wdata_d;
  logic [255:0]            data_q, data_d;
  logic [255:0]            mem_q [LINES];

  logic [DEPTH_LOG2-1:0]   addr_idx, req_idx;
  logic                    addr_err, req_wr, req_err, enter_ack, mem_we;
  logic [255:0]            req_wdata;

  assign addr_idx = addr_i[DEPTH_LOG2+4:5];

`ifdef DCACHE_MEM_ADDR_CHECK_EN
  assign addr_err = (addr_i[4:0] != 5'd0) || (addr_i[31:DEPTH_LOG2+5] != '0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:DEPTH_LOG2+5], addr_i[4:0]};
  assign addr_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    err_d     = err_q;
    wdata_d   = wdata_q;
    data_d    = data_q;
    enter_ack = 1'b0;
    req_idx   = idx_q;
    req_wr    = wr_q;
    req_err   = err_q;
    req_wdata = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          idx_d   = addr_idx;
          wr_d    = write_i;
          err_d   = addr_err;
          wdata_d = data_i;
          cnt_d   = CNT_INIT;
          // With single-edge latency the access happens on the accepting edge,
          // so the live request is used instead of the latched copy.
          req_idx   = addr_idx;
          req_wr    = write_i;
          req_err   = addr_err;
          req_wdata = data_i;
          if (LATENCY == 1) begin
            state_d   = ST_ACK;
            enter_ack = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d   = ST_ACK;
            enter_ack = 1'b1;
          end
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    mem_we = rst_i && enter_ack && req_wr && !req_err;
    if (enter_ack && !req_wr) begin
      data_d = req_err ? {256{1'b1}} : mem_q[req_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end

  // Array contents survive reset; they are preloaded or written through the port.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[req_idx] <= req_wdata;
    end
  end

  assign ack_o  = (state_q == ST_ACK);
  assign data_o = data_q;
`ifdef DCACHE_MEM_ADDR_CHECK_EN
  assign err_o  = ack_o && err_q;
`endif

endmodule
